demux_stream_n: RTL and testbench
=================================

Name: demux_stream_n

Overview:
- Parametrised, registered 1-to-NCH stream demultiplexer with valid/ready handshake on every channel.
- Routes each input word to the channel chosen by a sideband select, through a one-entry output register per channel.
- Provides backpressure, a bad-select error pulse and deterministic zero on idle outputs.
- Sits between a single producer and NCH independent consumers in datapath builds.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- NCH, 4, number of output channels (2..16, need not be a power of 2).
- SELW, $clog2(NCH), select width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept input this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  destination channel index; sampled together with in_data.
- out_valid  output  NCH  per-channel valid; bit k belongs to channel k.
- out_ready  input  NCH  per-channel ready from consumers.
- out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- err_badsel  output  1  one-cycle pulse when a word with in_sel >= NCH is accepted.

Behaviour:
- Reset (async assert, sync-release assumed upstream): out_valid=0, out_data=0, err_badsel=0. in_ready is combinational and reads 1 during reset-deasserted idle.
- Accept condition: in_valid && in_ready at a rising edge of clk.
- Channel k is free when !out_valid[k] || out_ready[k].
- in_ready = free[in_sel] when in_sel < NCH; in_ready = 1 when in_sel >= NCH.
- in_ready is combinational from in_sel, out_valid and out_ready. It has no dependency on in_valid.
- On accept with in_sel=k < NCH: channel k register loads in_data and out_valid[k]=1 on the next cycle. Latency is 1 clock.
- Output transfer: when out_valid[k] && out_ready[k], channel k has completed a transfer.
  - If no new load targets k in the same cycle, out_valid[k]=0 and the channel k data slice returns to 0 next cycle.
  - If a new load targets k in the same cycle, the new word replaces it with no bubble. Full throughput is 1 word/clock per channel.
- Idle channels always drive out_data slice = 0; no held or stale data is visible when valid=0.
- Held word: while out_valid[k]=1 && out_ready[k]=0, the channel k slice and out_valid[k] stay stable.
- Channels are independent; a stalled channel blocks the input only when in_sel selects it (head-of-line at input only).
- Bad select: an accepted word with in_sel >= NCH is discarded. err_badsel=1 for exactly the next cycle and no channel changes. Back-to-back bad selects give a continuous high.
- Reset mid-operation: all registered words are lost, all valids go 0 immediately (asynchronous), and err_badsel goes 0.
- Purely synchronous-to-clk except reset; no latches; every output is fully assigned in every branch.

Optional Feature:
- Macro DEMUX_STREAM_BROADCAST_EN.
- When defined:
  - Adds input port in_bcast (1 bit).
  - An accepted word with in_bcast=1 loads every channel and sets all NCH out_valid bits next cycle. in_sel is ignored and no err_badsel is raised.
  - in_ready for a broadcast word = AND of free[k] over all k.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset, then idle: rst_n low then high, in_valid=0 -> out_valid=0, out_data all zero, err_badsel=0, in_ready=1.
- Routing: WIDTH=8, NCH=4, send 0xA5 with sel=2 and all out_ready=1 -> next cycle out_valid=4'b0100, slice2=0xA5, other slices 0. The following cycle (no new input), out_valid=0.
- Backpressure: out_ready[1]=0, send 0x11 then 0x22 with sel=1 -> 0x11 held on slice1; in_ready=0 for the second word until out_ready[1]=1. Then 0x22 appears one cycle later with no loss or duplication.
- Simultaneous drain and load: sel=3 streaming 0x01,0x02,0x03 each cycle with out_ready[3]=1 -> slice3 shows 0x01,0x02,0x03 on consecutive cycles with out_valid[3] continuously high.
- Bad select: NCH=3, send sel=3 -> in_ready=1, err_badsel high for exactly one cycle, out_valid stays 0. Then reset mid-stream with channel 0 holding 0x7E -> out_valid and out_data clear asynchronously.
- Broadcast (DEMUX_STREAM_BROADCAST_EN): in_bcast=1, data 0x3C, all ready -> all slices 0x3C, out_valid=4'b1111. Repeat with out_ready[0]=0 and out_valid[0]=1 -> in_ready=0 until channel 0 drains.

Source files
------------

// File: rtl/demux_stream_n.sv
// demux_stream_n: registered 1-to-NCH valid/ready stream demux; `DEMUX_STREAM_BROADCAST_EN adds in_bcast broadcast.
module demux_stream_n #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
`ifdef DEMUX_STREAM_BROADCAST_EN
  input  logic                 in_bcast,
`endif
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 err_badsel
);
  localparam int NS = 2 ** SELW;
  localparam logic [SELW:0] NCH_W = NCH[SELW:0];
  logic [NCH-1:0] valid_q, valid_d, free, load;
  logic [NCH-1:0][WIDTH-1:0] data_q, data_d;
  logic [NS-1:0] free_pad, sel_oh;
  logic err_q, bcast, bad, acc;
`ifdef DEMUX_STREAM_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif
  assign free = ~valid_q | out_ready;
  // Out-of-range selects index padding bits that read as free, so bad words are always accepted.
  always_comb begin
    free_pad = '1;
    free_pad[NCH-1:0] = free;
  end
  assign bad = {1'b0, in_sel} >= NCH_W;
  assign sel_oh = NS'(1) << in_sel;
  assign in_ready = bcast ? &free : free_pad[in_sel];
  assign acc = in_valid && in_ready;
  assign load = acc ? (bcast ? '1 : sel_oh[NCH-1:0]) : '0;
  assign valid_d = load | (valid_q & ~out_ready);
  // Slices clear to zero whenever their channel goes idle.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < NCH; k++)
      data_d[k] = load[k] ? in_data : (valid_d[k] ? data_q[k] : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      err_q <= acc && bad && !bcast;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign err_badsel = err_q;
endmodule

// File: tb/tb_demux_stream_n.sv
// tb_demux_stream_n: directed vector bench for demux_stream_n (NCH=4 and NCH=3 instances).
module tb_demux_stream_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v4 = 1'b0, ir4, err4;
  logic [1:0] sel4 = '0;
  logic [7:0] d4 = '0;
  logic [3:0] rdy4 = '0, ov4;
  logic [31:0] od4;
  logic v3 = 1'b0, ir3, err3;
  logic [1:0] sel3 = '0;
  logic [7:0] d3 = '0;
  logic [2:0] rdy3 = '0, ov3;
  logic [23:0] od3;
`ifdef DEMUX_STREAM_BROADCAST_EN
  logic b4 = 1'b0;
  logic b3 = 1'b0;
`endif
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_stream_n #(.WIDTH(8), .NCH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_data(d4), .in_sel(sel4),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .in_bcast(b4),
`endif
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .err_badsel(err4)
  );

  demux_stream_n #(.WIDTH(8), .NCH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .in_data(d3), .in_sel(sel3),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .in_bcast(b3),
`endif
    .out_valid(ov3), .out_ready(rdy3), .out_data(od3), .err_badsel(err3)
  );

  typedef struct {
    logic v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] rdy;
    logic ir;
    logic [3:0] ov;
    logic [31:0] od;
    logic err;
  } vec_t;
  vec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step3(input string tag, input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [2:0] rdy, input logic e_ir, input logic [2:0] e_ov,
                       input logic [23:0] e_od, input logic e_err);
    v3 = v; sel3 = sel; d3 = d; rdy3 = rdy;
    #1 chk({tag, ".in_ready"}, 32'(ir3), 32'(e_ir));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(ov3), 32'(e_ov));
    chk({tag, ".out_data"}, 32'(od3), 32'(e_od));
    chk({tag, ".err"}, 32'(err3), 32'(e_err));
  endtask

`ifdef DEMUX_STREAM_BROADCAST_EN
  task automatic stepb(input string tag, input logic [3:0] rdy, input logic e_ir,
                       input logic [3:0] e_ov, input logic [31:0] e_od);
    v4 = 1'b1; b4 = 1'b1; d4 = 8'h3C; sel4 = 2'd1; rdy4 = rdy;
    #1 chk({tag, ".in_ready"}, 32'(ir4), 32'(e_ir));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(ov4), 32'(e_ov));
    chk({tag, ".out_data"}, od4, e_od);
    chk({tag, ".err"}, 32'(err4), 32'(0));
  endtask
`endif

  initial begin
    tv[0]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000, 1'b0};
    tv[1]  = '{1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 32'h00A50000, 1'b0};
    tv[2]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000, 1'b0};
    tv[3]  = '{1'b1, 2'd1, 8'h11, 4'hD, 1'b1, 4'b0010, 32'h00001100, 1'b0};
    tv[4]  = '{1'b1, 2'd1, 8'h22, 4'hD, 1'b0, 4'b0010, 32'h00001100, 1'b0};
    tv[5]  = '{1'b1, 2'd1, 8'h22, 4'hD, 1'b0, 4'b0010, 32'h00001100, 1'b0};
    tv[6]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 32'h00002200, 1'b0};
    tv[7]  = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000, 1'b0};
    tv[8]  = '{1'b1, 2'd3, 8'h01, 4'hF, 1'b1, 4'b1000, 32'h01000000, 1'b0};
    tv[9]  = '{1'b1, 2'd3, 8'h02, 4'hF, 1'b1, 4'b1000, 32'h02000000, 1'b0};
    tv[10] = '{1'b1, 2'd3, 8'h03, 4'hF, 1'b1, 4'b1000, 32'h03000000, 1'b0};
    tv[11] = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000, 1'b0};
    tv[12] = '{1'b1, 2'd0, 8'h55, 4'hE, 1'b1, 4'b0001, 32'h00000055, 1'b0};
    tv[13] = '{1'b1, 2'd2, 8'h66, 4'hE, 1'b1, 4'b0101, 32'h00660055, 1'b0};
    tv[14] = '{1'b1, 2'd0, 8'h77, 4'hE, 1'b0, 4'b0001, 32'h00000055, 1'b0};
    tv[15] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000, 1'b0};
    #2;
    chk("rst.out_valid", 32'(ov4), 32'(0));
    chk("rst.out_data", od4, 32'(0));
    chk("rst.err", 32'(err4), 32'(0));
    chk("rst.in_ready", 32'(ir4), 32'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.out_valid", 32'(ov4), 32'(0));
    chk("idle.in_ready", 32'(ir4), 32'(1));
    for (int i = 0; i < 16; i++) begin
      v4 = tv[i].v; sel4 = tv[i].sel; d4 = tv[i].d; rdy4 = tv[i].rdy;
      #1 chk($sformatf("vec%0d.in_ready", i), 32'(ir4), 32'(tv[i].ir));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.out_valid", i), 32'(ov4), 32'(tv[i].ov));
      chk($sformatf("vec%0d.out_data", i), od4, tv[i].od);
      chk($sformatf("vec%0d.err", i), 32'(err4), 32'(tv[i].err));
    end
`ifdef DEMUX_STREAM_BROADCAST_EN
    stepb("bc0", 4'hF, 1'b1, 4'b1111, 32'h3C3C3C3C);
    stepb("bc1", 4'hE, 1'b0, 4'b0001, 32'h0000003C);
    stepb("bc2", 4'hE, 1'b0, 4'b0001, 32'h0000003C);
    stepb("bc3", 4'hF, 1'b1, 4'b1111, 32'h3C3C3C3C);
    b4 = 1'b0; v4 = 1'b0;
    @(posedge clk); #1;
    chk("bc.drain", 32'(ov4), 32'(0));
`endif
    step3("bad0", 1'b1, 2'd3, 8'h99, 3'b111, 1'b1, 3'b000, 24'h0, 1'b1);
    step3("bad1", 1'b0, 2'd3, 8'h00, 3'b111, 1'b1, 3'b000, 24'h0, 1'b0);
    step3("bad2", 1'b1, 2'd3, 8'h98, 3'b111, 1'b1, 3'b000, 24'h0, 1'b1);
    step3("bad3", 1'b1, 2'd3, 8'h97, 3'b111, 1'b1, 3'b000, 24'h0, 1'b1);
    step3("bad4", 1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 24'h0, 1'b0);
    step3("hold0", 1'b1, 2'd0, 8'h7E, 3'b000, 1'b1, 3'b001, 24'h00007E, 1'b0);
    step3("hold1", 1'b0, 2'd0, 8'h00, 3'b000, 1'b0, 3'b001, 24'h00007E, 1'b0);
    v3 = 1'b1; sel3 = 2'd3; d3 = 8'h42;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(ov3), 32'(0));
    chk("arst.out_data", 32'(od3), 32'(0));
    chk("arst.err", 32'(err3), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
